// File: rtl/ddr3_dma_read_if.sv
// ddr3_dma_read_if: AXI4 read channels, DMA request and output stream bundle for ddr3_dma_read
interface ddr3_dma_read_if #(
   parameter int DMA_ADDR_WIDTH     = 27,
   parameter int C_M_AXI_ID_WIDTH   = 4,
   parameter int C_M_AXI_ADDR_WIDTH = 32,
   parameter int C_M_AXI_DATA_WIDTH = 512
) ();
   logic [C_M_AXI_ADDR_WIDTH-1:0] m_axi_araddr;
   logic [7:0]                    m_axi_arlen;
   logic [2:0]                    m_axi_arsize;
   logic [1:0]                    m_axi_arburst;
   logic [3:0]                    m_axi_arcache;
   logic [C_M_AXI_ID_WIDTH-1:0]   m_axi_arid;
   logic                          m_axi_arlock;
   logic [2:0]                    m_axi_arprot;
   logic [3:0]                    m_axi_arqos;
   logic                          m_axi_aruser;
   logic                          m_axi_arvalid;
   logic                          m_axi_arready;
   logic [C_M_AXI_DATA_WIDTH-1:0] m_axi_rdata;
   logic [1:0]                    m_axi_rresp;
   logic                          m_axi_rlast;
   logic [C_M_AXI_ID_WIDTH-1:0]   m_axi_rid;
   logic                          m_axi_rvalid;
   logic                          m_axi_rready;
   logic                          read_req;
   logic [DMA_ADDR_WIDTH-1:0]     read_start_addr;
   logic [DMA_ADDR_WIDTH-1:0]     read_length;
   logic                          read_busy;
   logic                          read_done;
   logic [C_M_AXI_DATA_WIDTH-1:0] dout;
   logic                          dout_valid;
   logic                          dout_rdy;
   logic                          dout_eop;
   logic                          read_err;

   modport master (
      output m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst, m_axi_arcache, m_axi_arid,
             m_axi_arlock, m_axi_arprot, m_axi_arqos, m_axi_aruser, m_axi_arvalid, m_axi_rready,
             read_busy, read_done, dout, dout_valid, dout_eop, read_err,
      input  m_axi_arready, m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_rid, m_axi_rvalid,
             read_req, read_start_addr, read_length, dout_rdy
   );

   modport slave (
      input  m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst, m_axi_arcache, m_axi_arid,
             m_axi_arlock, m_axi_arprot, m_axi_arqos, m_axi_aruser, m_axi_arvalid, m_axi_rready,
             read_busy, read_done, dout, dout_valid, dout_eop, read_err,
      output m_axi_arready, m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_rid, m_axi_rvalid,
             read_req, read_start_addr, read_length, dout_rdy
   );
endinterface

// File: rtl/ddr3_dma_read.sv
// ddr3_dma_read: AXI4 INCR-burst read master feeding a credit-protected FIFO and a valid/ready stream.
// Optional RRESP error flag enabled by defining DDR3_DMA_READ_RRESP_CHECK_EN.
module ddr3_dma_read #(
   parameter int DMA_ADDR_WIDTH     = 27,
   parameter int C_M_AXI_ID_WIDTH   = 4,
   parameter int C_M_AXI_BURST_LEN  = 16,
   parameter int C_M_AXI_ADDR_WIDTH = 32,
   parameter int C_M_AXI_DATA_WIDTH = 512,
   parameter int FIFO_DEPTH         = 64
) (
   input logic clk,
   input logic rst,
   ddr3_dma_read_if.master bus
);
   localparam int BYTES = C_M_AXI_DATA_WIDTH / 8;
   localparam int AW    = $clog2(FIFO_DEPTH);
   localparam int CW    = AW + 1;
   localparam logic [DMA_ADDR_WIDTH-1:0] BL = DMA_ADDR_WIDTH'(C_M_AXI_BURST_LEN);
   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ADDR  = 2'd1;
   localparam logic [1:0] S_DRAIN = 2'd2;

   logic [1:0]                    r_state;
   logic [DMA_ADDR_WIDTH-1:0]     r_ar_left;
   logic [DMA_ADDR_WIDTH-1:0]     r_beat_left;
   logic [C_M_AXI_ADDR_WIDTH-1:0] r_araddr;
   logic [7:0]                    r_arlen;
   logic                          r_arvalid;
   logic                          r_done;
   logic [CW-1:0]                 r_count;
   logic [CW-1:0]                 r_outstanding;
   logic [AW-1:0]                 r_wr_ptr;
   logic [AW-1:0]                 r_rd_ptr;
   logic [C_M_AXI_DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];

   logic [DMA_ADDR_WIDTH-1:0] w_n;
   logic [DMA_ADDR_WIDTH-1:0] w_req_n;
   logic                      w_credit_ok;
   logic                      w_ar_hs;
   logic                      w_r_hs;
   logic                      w_dout_valid;
   logic                      w_out_hs;
   logic                      w_req;
   logic                      w_err;
   logic                      w_unused;

   assign w_n          = (r_ar_left > BL) ? BL : r_ar_left;
   assign w_req_n      = (bus.read_length > BL) ? BL : bus.read_length;
   // Space left after buffered beats and beats already requested but not yet returned
   assign w_credit_ok  = 32'(r_count) + 32'(r_outstanding) + 32'(w_n) <= 32'(FIFO_DEPTH);
   assign w_ar_hs      = r_arvalid & bus.m_axi_arready;
   assign w_r_hs       = bus.m_axi_rvalid;
   assign w_dout_valid = r_count != '0;
   assign w_out_hs     = w_dout_valid & bus.dout_rdy;
   assign w_req        = bus.read_req & (r_state == S_IDLE);
   assign w_unused     = ^{bus.m_axi_rid, bus.m_axi_rlast, bus.m_axi_rresp};

   // Request capture, AR burst issue under FIFO credit, and completion tracking
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_ar_left   <= '0;
         r_beat_left <= '0;
         r_araddr    <= '0;
         r_arlen     <= '0;
         r_arvalid   <= 1'b0;
         r_done      <= 1'b0;
      end else begin
         r_done <= 1'b0;
         if (w_out_hs) r_beat_left <= r_beat_left - 1'b1;
         if (r_state == S_IDLE) begin
            if (bus.read_req) begin
               // FIFO is empty and nothing is outstanding when idle, so the first burst needs no credit wait
               r_state     <= S_ADDR;
               r_ar_left   <= bus.read_length;
               r_beat_left <= bus.read_length;
               r_araddr    <= C_M_AXI_ADDR_WIDTH'(bus.read_start_addr);
               r_arlen     <= 8'(w_req_n - 1);
               r_arvalid   <= 1'b1;
            end
         end else if (r_state == S_ADDR) begin
            if (w_ar_hs) begin
               r_arvalid <= 1'b0;
               r_araddr  <= r_araddr + C_M_AXI_ADDR_WIDTH'(w_n * BYTES);
               r_ar_left <= r_ar_left - w_n;
               if (r_ar_left == w_n) r_state <= S_DRAIN;
            end else if (!r_arvalid && w_credit_ok) begin
               r_arvalid <= 1'b1;
               r_arlen   <= 8'(w_n - 1);
            end
         end else if (w_out_hs && r_beat_left == 1) begin
            r_state <= S_IDLE;
            r_done  <= 1'b1;
         end
      end
   end

   // FIFO occupancy, outstanding-beat credit and pointers
   always_ff @(posedge clk) begin
      if (rst) begin
         r_count       <= '0;
         r_outstanding <= '0;
         r_wr_ptr      <= '0;
         r_rd_ptr      <= '0;
      end else begin
         r_count       <= r_count + CW'(w_r_hs) - CW'(w_out_hs);
         r_outstanding <= r_outstanding + (w_ar_hs ? CW'(w_n) : CW'(0)) - CW'(w_r_hs);
         if (w_r_hs) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_out_hs) r_rd_ptr <= r_rd_ptr + 1'b1;
      end
   end

   // FIFO storage; every R beat is written since rready is always high
   always_ff @(posedge clk) begin
      if (w_r_hs) r_mem[r_wr_ptr] <= bus.m_axi_rdata;
   end

`ifdef DDR3_DMA_READ_RRESP_CHECK_EN
   logic r_err;
   // Sticky SLVERR/DECERR flag, cleared when the next transfer is accepted
   always_ff @(posedge clk) begin
      if (rst) r_err <= 1'b0;
      else if (w_req) r_err <= 1'b0;
      else if (w_r_hs && bus.m_axi_rresp[1]) r_err <= 1'b1;
   end
   assign w_err = r_err;
`else
   assign w_err = 1'b0;
`endif

   assign bus.m_axi_araddr  = r_araddr;
   assign bus.m_axi_arlen   = r_arlen;
   assign bus.m_axi_arsize  = 3'($clog2(BYTES));
   assign bus.m_axi_arburst = 2'b01;
   assign bus.m_axi_arcache = 4'b0010;
   assign bus.m_axi_arid    = '0;
   assign bus.m_axi_arlock  = 1'b0;
   assign bus.m_axi_arprot  = 3'b000;
   assign bus.m_axi_arqos   = 4'b0000;
   assign bus.m_axi_aruser  = 1'b1;
   assign bus.m_axi_arvalid = r_arvalid;
   assign bus.m_axi_rready  = 1'b1;
   assign bus.read_busy     = r_state != S_IDLE;
   assign bus.read_done     = r_done;
   assign bus.dout          = r_mem[r_rd_ptr];
   assign bus.dout_valid    = w_dout_valid;
   assign bus.dout_eop      = w_dout_valid & (r_beat_left == 1);
   assign bus.read_err      = w_err;
endmodule

// File: tb/tb_ddr3_dma_read.sv
// tb_ddr3_dma_read: scoreboard bench with an AXI slave model for ddr3_dma_read
module tb_ddr3_dma_read;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   ddr3_dma_read_if bus ();
   ddr3_dma_read dut (.clk(clk), .rst(rst), .bus(bus));

   int checks = 0;
   int errors = 0;
   logic [511:0] exp_d[$];
   logic         exp_eop[$];
   logic [31:0]  exp_ara[$];
   logic [7:0]   exp_arl[$];
   logic [31:0]  sl_addr[$];
   logic         sl_last[$];
   int  ar_stall = 0;
   int  err_beat = -1;
   int  beat_no = 0;
   int  issued = 0;
   int  consumed = 0;
   bit  flush = 0;
   bit  exp_done = 0;
   bit  rand_rdy = 0;
   bit  ar_held = 0;
   logic [31:0] held_addr;
   logic [7:0]  held_len;

   function automatic logic [511:0] pat(input logic [31:0] a);
      return {8{a, ~a}};
   endfunction

   // AXI slave model: drives R beats from queued bursts and checks AR channel
   initial begin
      bus.m_axi_arready = 0;
      bus.m_axi_rvalid = 0;
      bus.m_axi_rdata = '0;
      bus.m_axi_rresp = 2'b00;
      bus.m_axi_rlast = 0;
      bus.m_axi_rid = '0;
      forever begin
         @(negedge clk);
         if (flush) begin
            sl_addr.delete();
            sl_last.delete();
            bus.m_axi_rvalid = 0;
            bus.m_axi_arready = 0;
            ar_held = 0;
            continue;
         end
         if (sl_addr.size() > 0) begin
            bus.m_axi_rvalid = 1;
            bus.m_axi_rdata = pat(sl_addr.pop_front());
            bus.m_axi_rlast = sl_last.pop_front();
            bus.m_axi_rresp = (beat_no == err_beat) ? 2'b10 : 2'b00;
            beat_no++;
         end else begin
            bus.m_axi_rvalid = 0;
         end
         bus.m_axi_arready = 0;
         if (bus.m_axi_arvalid) begin
            if (!ar_held) begin
               ar_held = 1;
               held_addr = bus.m_axi_araddr;
               held_len = bus.m_axi_arlen;
            end else begin
               checks++;
               if (bus.m_axi_araddr !== held_addr || bus.m_axi_arlen !== held_len) begin
                  errors++;
                  $display("FAIL ar_stable addr=%h len=%0d required addr=%h len=%0d", bus.m_axi_araddr, bus.m_axi_arlen, held_addr, held_len);
               end
            end
            if (ar_stall > 0) ar_stall--;
            else begin
               bus.m_axi_arready = 1;
               ar_held = 0;
               checks++;
               if (exp_ara.size() == 0) begin
                  errors++;
                  $display("FAIL ar_unexpected addr=%h len=%0d required none", bus.m_axi_araddr, bus.m_axi_arlen);
               end else begin
                  logic [31:0] ea;
                  logic [7:0] el;
                  ea = exp_ara.pop_front();
                  el = exp_arl.pop_front();
                  if (bus.m_axi_araddr !== ea || bus.m_axi_arlen !== el) begin
                     errors++;
                     $display("FAIL ar_burst addr=%h len=%0d required addr=%h len=%0d", bus.m_axi_araddr, bus.m_axi_arlen, ea, el);
                  end
               end
               for (int k = 0; k <= int'(bus.m_axi_arlen); k++) begin
                  sl_addr.push_back(bus.m_axi_araddr + 32'(k * 64));
                  sl_last.push_back(k == int'(bus.m_axi_arlen));
               end
               issued += int'(bus.m_axi_arlen) + 1;
            end
         end
      end
   end

   // Output monitor: scoreboard compare, stability while stalled, done pulse timing
   initial begin
      bit prev_hold;
      logic [511:0] prev_d;
      prev_hold = 0;
      prev_d = '0;
      forever begin
         @(negedge clk);
         if (flush) begin
            prev_hold = 0;
            exp_done = 0;
            continue;
         end
         if (exp_done) begin
            checks++;
            if (bus.read_done !== 1'b1 || bus.read_busy !== 1'b0) begin
               errors++;
               $display("FAIL done_pulse done=%b busy=%b required done=1 busy=0", bus.read_done, bus.read_busy);
            end
            exp_done = 0;
         end else if (bus.read_done !== 1'b0) begin
            checks++;
            errors++;
            $display("FAIL done_spurious done=%b required 0", bus.read_done);
         end
         if (prev_hold) begin
            checks++;
            if (bus.dout_valid !== 1'b1 || bus.dout !== prev_d) begin
               errors++;
               $display("FAIL dout_stable valid=%b data=%h required valid=1 data=%h", bus.dout_valid, bus.dout[63:0], prev_d[63:0]);
            end
         end
         prev_hold = bus.dout_valid & ~bus.dout_rdy;
         prev_d = bus.dout;
         if (bus.dout_valid && bus.dout_rdy) begin
            checks++;
            consumed++;
            if (exp_d.size() == 0) begin
               errors++;
               $display("FAIL dout_unexpected data=%h required none", bus.dout[63:0]);
            end else begin
               logic [511:0] ed;
               logic ee;
               ed = exp_d.pop_front();
               ee = exp_eop.pop_front();
               if (bus.dout !== ed || bus.dout_eop !== ee) begin
                  errors++;
                  $display("FAIL dout_beat data=%h eop=%b required data=%h eop=%b", bus.dout[63:0], bus.dout_eop, ed[63:0], ee);
               end
               if (ee) exp_done = 1;
            end
         end
      end
   end

   task automatic start_read(input logic [31:0] a, input int len);
      int left;
      logic [31:0] ad;
      for (int i = 0; i < len; i++) begin
         exp_d.push_back(pat(a + 32'(i * 64)));
         exp_eop.push_back(i == len - 1);
      end
      left = len;
      ad = a;
      while (left > 0) begin
         int n;
         n = (left > 16) ? 16 : left;
         exp_ara.push_back(ad);
         exp_arl.push_back(8'(n - 1));
         ad += 32'(n * 64);
         left -= n;
      end
      beat_no = 0;
      bus.read_req = 1;
      bus.read_start_addr = 27'(a);
      bus.read_length = 27'(len);
      @(posedge clk); #1;
      bus.read_req = 0;
      checks++;
      if (bus.read_busy !== 1'b1) begin
         errors++;
         $display("FAIL busy_start busy=%b required 1", bus.read_busy);
      end
   endtask

   task automatic wait_idle(input int maxc, output bit ok);
      ok = 0;
      for (int i = 0; i < maxc; i++) begin
         @(posedge clk); #1;
         if (rand_rdy) bus.dout_rdy = 1'($urandom_range(0, 1));
         if (exp_d.size() == 0 && !bus.read_busy && !exp_done) begin
            ok = 1;
            break;
         end
      end
   endtask

   task automatic test_reset;
      rst = 1;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if ({bus.m_axi_arvalid, bus.read_busy, bus.read_done, bus.dout_valid, bus.dout_eop, bus.read_err} !== 6'b0) begin
         errors++;
         $display("FAIL reset_flags arv/busy/done/dv/eop/err=%b required 000000",
                  {bus.m_axi_arvalid, bus.read_busy, bus.read_done, bus.dout_valid, bus.dout_eop, bus.read_err});
      end
      checks++;
      if (bus.m_axi_araddr !== 32'h0 || bus.m_axi_rready !== 1'b1) begin
         errors++;
         $display("FAIL reset_addr araddr=%h rready=%b required 0 1", bus.m_axi_araddr, bus.m_axi_rready);
      end
      rst = 0;
      @(posedge clk); #1;
   endtask

   task automatic test_single;
      bit ok;
      bus.dout_rdy = 1;
      start_read(32'h1000, 1);
      wait_idle(200, ok);
      checks++;
      if (!ok || exp_ara.size() != 0) begin
         errors++;
         $display("FAIL single_complete ok=%b ar_left=%0d required 1 0", ok, exp_ara.size());
      end
   endtask

   task automatic test_multi;
      bit ok;
      rand_rdy = 1;
      start_read(32'h0, 40);
      wait_idle(2000, ok);
      rand_rdy = 0;
      bus.dout_rdy = 1;
      checks++;
      if (!ok || exp_ara.size() != 0) begin
         errors++;
         $display("FAIL multi_complete ok=%b ar_left=%0d required 1 0", ok, exp_ara.size());
      end
   endtask

   task automatic test_backpressure;
      bit ok;
      bus.dout_rdy = 0;
      issued = 0;
      consumed = 0;
      start_read(32'h4000, 128);
      repeat (200) @(posedge clk);
      #1;
      checks++;
      if (issued != 64 || consumed != 0 || bus.dout_valid !== 1'b1) begin
         errors++;
         $display("FAIL bp_credit issued=%0d consumed=%0d valid=%b required 64 0 1", issued, consumed, bus.dout_valid);
      end
      bus.dout_rdy = 1;
      wait_idle(3000, ok);
      checks++;
      if (!ok || issued != 128 || consumed != 128) begin
         errors++;
         $display("FAIL bp_complete ok=%b issued=%0d consumed=%0d required 1 128 128", ok, issued, consumed);
      end
   endtask

   task automatic test_slow_slave;
      bit ok;
      ar_stall = 10;
      start_read(32'h8000, 20);
      wait_idle(2000, ok);
      checks++;
      if (!ok || exp_ara.size() != 0 || ar_stall != 0) begin
         errors++;
         $display("FAIL slow_complete ok=%b ar_left=%0d stall=%0d required 1 0 0", ok, exp_ara.size(), ar_stall);
      end
   endtask

   task automatic test_error;
      bit ok;
      logic want;
`ifdef DDR3_DMA_READ_RRESP_CHECK_EN
      want = 1'b1;
`else
      want = 1'b0;
`endif
      err_beat = 2;
      start_read(32'hC000, 8);
      wait_idle(500, ok);
      err_beat = -1;
      checks++;
      if (!ok || bus.read_err !== want) begin
         errors++;
         $display("FAIL err_set ok=%b err=%b required 1 %b", ok, bus.read_err, want);
      end
      repeat (5) @(posedge clk);
      #1;
      checks++;
      if (bus.read_err !== want) begin
         errors++;
         $display("FAIL err_sticky err=%b required %b", bus.read_err, want);
      end
      start_read(32'hC000, 1);
      checks++;
      if (bus.read_err !== 1'b0) begin
         errors++;
         $display("FAIL err_clear err=%b required 0", bus.read_err);
      end
      wait_idle(200, ok);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL err_followup ok=%b required 1", ok);
      end
   endtask

   task automatic test_reset_mid;
      bit ok;
      int i;
      bus.dout_rdy = 1;
      consumed = 0;
      start_read(32'h10000, 64);
      for (i = 0; i < 1000 && consumed < 20; i++) begin
         @(posedge clk); #1;
      end
      checks++;
      if (consumed < 20) begin
         errors++;
         $display("FAIL mid_progress consumed=%0d required 20", consumed);
      end
      flush = 1;
      rst = 1;
      bus.dout_rdy = 0;
      @(posedge clk); #1;
      checks++;
      if ({bus.m_axi_arvalid, bus.read_busy, bus.read_done, bus.dout_valid, bus.dout_eop, bus.read_err} !== 6'b0 ||
          bus.m_axi_araddr !== 32'h0) begin
         errors++;
         $display("FAIL mid_reset flags=%b araddr=%h required 000000 0",
                  {bus.m_axi_arvalid, bus.read_busy, bus.read_done, bus.dout_valid, bus.dout_eop, bus.read_err}, bus.m_axi_araddr);
      end
      rst = 0;
      exp_d.delete();
      exp_eop.delete();
      exp_ara.delete();
      exp_arl.delete();
      @(posedge clk); #1;
      flush = 0;
      bus.dout_rdy = 1;
      @(posedge clk); #1;
      start_read(32'h20000, 4);
      wait_idle(200, ok);
      checks++;
      if (!ok || exp_ara.size() != 0) begin
         errors++;
         $display("FAIL mid_followup ok=%b ar_left=%0d required 1 0", ok, exp_ara.size());
      end
   endtask

   initial begin
      rst = 1;
      bus.read_req = 0;
      bus.read_start_addr = '0;
      bus.read_length = '0;
      bus.dout_rdy = 0;
      @(posedge clk); #1;
      test_reset();
      test_single();
      test_multi();
      test_backpressure();
      test_slow_slave();
      test_error();
      test_reset_mid();
      repeat (5) @(posedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog checks=%0d errors=%0d required completion", checks, errors);
      $fatal(1, "timeout");
   end
endmodule
